comparator_seq: RTL and testbench

COMPARATOR_SEQ -- requirements
Module: comparator_seq

---
 rtl/comparator_seq_if.sv | 33 +++
 rtl/comparator_seq.sv | 117 +++++++++++
 tb/tb_comparator_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_seq_if.sv
// rtl/comparator_seq_if.sv - request, operand, shared-comparator and result signals of comparator_seq
interface comparator_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   cmp_a;
    logic [3:0]   cmp_b;
    logic         cmp_gt;
    logic         cmp_lt;
    logic         cmp_eq;
    logic         busy;
    logic         done;
    logic         gt;
    logic         lt;
    logic         eq;
    logic         err;

    // Sequencer side: owns the comparator inputs and the result outputs.
    modport slave (
        input  start, op_a, op_b, cmp_gt, cmp_lt, cmp_eq,
        output cmp_a, cmp_b, busy, done, gt, lt, eq, err
    );

    // Requester / comparator side.
    modport master (
        output start, op_a, op_b, cmp_gt, cmp_lt, cmp_eq,
        input  cmp_a, cmp_b, busy, done, gt, lt, eq, err
    );
endinterface

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - MSB-first nibble-serial magnitude compare using one external 4-bit comparator
module comparator_seq #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    comparator_seq_if.slave  bus
);
    localparam int W = 4 * NIBBLES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] IDX_TOP = 4'(NIBBLES - 1);

    logic [1:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         gt_q, gt_d;
    logic         lt_q, lt_d;
    logic         eq_q, eq_d;
    logic         err_q, err_d;

    logic [W-1:0] a_sh;
    logic [W-1:0] b_sh;
    logic [2:0]   res;
    logic         onehot;

    // Present the current nibble to the comparator and decode status from the state.
    always_comb begin
        a_sh      = a_q >> {idx_q, 2'b00};
        b_sh      = b_q >> {idx_q, 2'b00};
        bus.cmp_a = (state_q == S_CMP) ? a_sh[3:0] : 4'd0;
        bus.cmp_b = (state_q == S_CMP) ? b_sh[3:0] : 4'd0;
        bus.busy  = (state_q == S_CMP);
        bus.done  = (state_q == S_DONE);
        bus.gt    = gt_q;
        bus.lt    = lt_q;
        bus.eq    = eq_q;
        bus.err   = err_q;
    end

    // Sequencing: accept outside CMP, walk nibbles MSB-first, stop at the first difference.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        err_d   = err_q;
        res     = {bus.cmp_gt, bus.cmp_lt, bus.cmp_eq};
        onehot  = (res == 3'b100) || (res == 3'b010) || (res == 3'b001);

        case (state_q)
            S_CMP: begin
                if (!onehot) begin
                    // A broken comparator gives no trustworthy ordering, so report only err.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (bus.cmp_eq) begin
                    if (idx_q == 4'd0) begin
                        eq_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end else begin
                    gt_d    = bus.cmp_gt;
                    lt_d    = bus.cmp_lt;
                    state_d = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    idx_d   = IDX_TOP;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_CMP;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State, operand latches and result registers; reset abandons any compare in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - randomized self-checking bench for comparator_seq against a nibble-order model
module tb_comparator_seq;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comparator_seq_if #(.NIBBLES(NIBBLES)) bus();
    comparator_seq #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Shared 4-bit comparator with an override to inject non-one-hot results.
    logic       fault_en = 1'b0;
    logic [2:0] fault_res = 3'b000;
    assign bus.cmp_gt = fault_en ? fault_res[2] : (bus.cmp_a > bus.cmp_b);
    assign bus.cmp_lt = fault_en ? fault_res[1] : (bus.cmp_a < bus.cmp_b);
    assign bus.cmp_eq = fault_en ? fault_res[0] : (bus.cmp_a == bus.cmp_b);

    int total = 0;
    int bad = 0;

    // Expected latency and {gt,lt,eq,err} from the first differing nibble and plain magnitude compare.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int lat, output logic [3:0] res);
        int  j;
        bit  found;
        j = NIBBLES - 1;
        found = 0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (!found && (((a >> (4 * (NIBBLES - 1 - k))) & 'hF) != ((b >> (4 * (NIBBLES - 1 - k))) & 'hF))) begin
                j = k;
                found = 1;
            end
        end
        lat = j + 2;
        if (a > b)      res = 4'b1000;
        else if (a < b) res = 4'b0100;
        else            res = 4'b0010;
    endfunction

    // Pulse start in cycle 0, scramble operands afterwards, and observe until done or timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                          output logic [3:0] res, output int busy_n, output logic [15:0] trace);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a = W'($urandom);
        bus.op_b = W'($urandom);
        lat = -1;
        res = 4'b0000;
        busy_n = 0;
        trace = 16'h0;
        for (int c = 1; c <= NIBBLES + 6 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                res = {bus.gt, bus.lt, bus.eq, bus.err};
            end else if (bus.busy) begin
                busy_n++;
                trace = {trace[11:0], bus.cmp_a};
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        #1;
        obs = {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.cmp_a, bus.cmp_b};
        total++;
        if (obs !== 14'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        obs = {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.cmp_a, bus.cmp_b};
        total++;
        if (obs !== 14'h0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", obs); end
    endtask

    task automatic test_equal();
        int lat, bn;
        logic [3:0] res;
        logic [15:0] tr;
        run_op(16'h1234, 16'h1234, lat, res, bn, tr);
        total++; if (lat !== 5) begin bad++; $display("FAIL eq_latency got=%0d exp=5", lat); end
        total++; if (res !== 4'b0010) begin bad++; $display("FAIL eq_result got=%b exp=0010", res); end
        total++; if (bn !== 4) begin bad++; $display("FAIL eq_busy_cycles got=%0d exp=4", bn); end
        total++; if (tr !== 16'h1234) begin bad++; $display("FAIL eq_cmp_a_trace got=%h exp=1234", tr); end
    endtask

    task automatic test_early();
        int lat, bn;
        logic [3:0] res;
        logic [15:0] tr;
        run_op(16'h8000, 16'h7FFF, lat, res, bn, tr);
        total++; if (lat !== 2) begin bad++; $display("FAIL msb_latency got=%0d exp=2", lat); end
        total++; if (res !== 4'b1000) begin bad++; $display("FAIL msb_result got=%b exp=1000", res); end
        total++; if (bn !== 1) begin bad++; $display("FAIL msb_busy_cycles got=%0d exp=1", bn); end
        run_op(16'h1230, 16'h1231, lat, res, bn, tr);
        total++; if (lat !== 5) begin bad++; $display("FAIL lsb_latency got=%0d exp=5", lat); end
        total++; if (res !== 4'b0100) begin bad++; $display("FAIL lsb_result got=%b exp=0100", res); end
    endtask

    task automatic test_random();
        int lat, bn, elat;
        logic [3:0] res, eres, held;
        logic [15:0] tr;
        logic [W-1:0] a, b;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0: b = W'($urandom);
                1: b = a ^ (W'(1) << $urandom_range(0, W - 1));
                2: b = a;
                default: b = a ^ (W'($urandom) & W'(16'h00FF));
            endcase
            model(a, b, elat, eres);
            run_op(a, b, lat, res, bn, tr);
            total++; if (lat !== elat) begin bad++; $display("FAIL rand_latency a=%h b=%h got=%0d exp=%0d", a, b, lat, elat); end
            total++; if (res !== eres) begin bad++; $display("FAIL rand_result a=%h b=%h got=%b exp=%b", a, b, res, eres); end
            @(negedge clk);
            held = {bus.gt, bus.lt, bus.eq, bus.err};
            total++; if ({bus.done, held} !== {1'b0, eres}) begin bad++; $display("FAIL rand_hold got=%b exp=0%b", {bus.done, held}, eres); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [3:0] res;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'h1234; bus.op_b = 16'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'h0001; bus.op_b = 16'h0002;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1; res = 4'b0;
        for (int c = 3; c <= 12 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.done) begin lat = c; res = {bus.gt, bus.lt, bus.eq, bus.err}; end
        end
        total++; if (lat !== 5) begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=5", lat); end
        total++; if (res !== 4'b0010) begin bad++; $display("FAIL busy_ignore_result got=%b exp=0010", res); end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        logic [3:0] res;
        logic [15:0] tr;
        run_op(16'h5555, 16'h5555, lat, res, bn, tr);
        total++; if (lat !== 5) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=5", lat); end
        bus.start = 1'b1; bus.op_a = 16'h00F0; bus.op_b = 16'h0F00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err} !== 6'b100000) begin
            bad++; $display("FAIL b2b_cmp_entry got=%b exp=100000", {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err});
        end
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_second_cmp got=%b exp=1", bus.busy); end
        @(negedge clk);
        total++;
        if ({bus.done, bus.gt, bus.lt, bus.eq, bus.err} !== 5'b10100) begin
            bad++; $display("FAIL b2b_result got=%b exp=10100", {bus.done, bus.gt, bus.lt, bus.eq, bus.err});
        end
    endtask

    task automatic test_reset_mid();
        int lat, bn, seen;
        logic [3:0] res;
        logic [15:0] tr;
        logic [13:0] obs;
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'h1234; bus.op_b = 16'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.err, bus.cmp_a, bus.cmp_b};
        total++; if (obs !== 14'h0) begin bad++; $display("FAIL mid_reset_outputs got=%h exp=0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (bus.done || bus.busy) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_reset_no_done got=%0d exp=0", seen); end
        run_op(16'hABCD, 16'hABCE, lat, res, bn, tr);
        total++; if ({lat[3:0], res} !== {4'd5, 4'b0100}) begin bad++; $display("FAIL post_reset_op got=%0d/%b exp=5/0100", lat, res); end
    endtask

    task automatic test_fault();
        int lat, bn;
        logic [3:0] res;
        logic [15:0] tr;
        logic [2:0] pats [3] = '{3'b101, 3'b000, 3'b111};
        for (int p = 0; p < 3; p++) begin
            fault_en = 1'b1;
            fault_res = pats[p];
            run_op(16'h1234, 16'h1234, lat, res, bn, tr);
            fault_en = 1'b0;
            total++; if (lat !== 2) begin bad++; $display("FAIL fault_latency pat=%b got=%0d exp=2", pats[p], lat); end
            total++; if (res !== 4'b0001) begin bad++; $display("FAIL fault_result pat=%b got=%b exp=0001", pats[p], res); end
        end
        @(negedge clk);
        bus.start = 1'b1; bus.op_a = 16'h0001; bus.op_b = 16'h0002;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        total++; if ({bus.busy, bus.err} !== 2'b10) begin bad++; $display("FAIL err_clear got=%b exp=10", {bus.busy, bus.err}); end
        lat = -1; res = 4'b0;
        for (int c = 2; c <= 12 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.done) begin lat = c; res = {bus.gt, bus.lt, bus.eq, bus.err}; end
        end
        total++; if ({lat[3:0], res} !== {4'd5, 4'b0100}) begin bad++; $display("FAIL after_fault_op got=%0d/%b exp=5/0100", lat, res); end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_early();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_fault();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
